// File: rtl/clut_pixel_arbiter.sv
// clut_pixel_arbiter
// Per-pixel front end for the CLUT: selects one colour index from two tile
// layers and the sprite layer by priority/opacity, defers CPU palette-bank
// changes to the next vertical-blank start, and provides a self-test sweep
// that steps every CLUT index once. All outputs come straight from flops.

module clut_pixel_arbiter #(
    parameter logic [7:0] BG_INDEX = 8'h00,
    parameter int         PRI_W    = 3
) (
    input  logic             CLK_6M,
    input  logic             CLR,
    input  logic             PIX_EN,
    input  logic             HBLANK,
    input  logic             VBLANK,
    input  logic [7:0]       L0_D,
    input  logic [PRI_W-1:0] L0_PRI,
    input  logic             L0_OPQ,
    input  logic [7:0]       L1_D,
    input  logic [PRI_W-1:0] L1_PRI,
    input  logic             L1_OPQ,
    input  logic [7:0]       SP_D,
    input  logic [PRI_W-1:0] SP_PRI,
    input  logic             SP_OPQ,
    input  logic             BANK_REQ,
    input  logic             BANK_SEL,
    output logic             BANK_PEND,
    input  logic             SWEEP_START,
    output logic             SWEEP_BUSY,
    output logic [7:0]       CLUT_D,
    output logic             CLUT_BANK,
    output logic             BLANK_OUT
);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_SWEEP  = 1'b1
    } state_t;

    // Pixel-path / sweep registers and their next values
    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_sweep_cnt;
    logic [7:0]       w_sweep_cnt_nxt;
    logic [7:0]       r_clut_d;
    logic [7:0]       w_clut_d_nxt;
    logic             r_blank;
    logic             w_blank_nxt;
    logic             r_sweep_busy;
    logic             w_sweep_busy_nxt;

    // Bank deferral registers
    logic             r_vblank_prev;
    logic             r_bank;
    logic             r_bank_pend;
    logic             r_pend_val;
    logic             w_vb_rise;

    // Arbitration result
    logic [7:0]       w_arb_d;
    logic [PRI_W-1:0] w_arb_pri;
    logic             w_arb_hit;

    assign w_vb_rise = VBLANK & ~r_vblank_prev;

    // Layer arbitration: layers are visited in tie-break order (SP, L0, L1)
    // and a later layer only replaces the current pick on a strictly higher
    // priority, so equal priorities keep the earlier layer.
    always_comb begin
        w_arb_hit = 1'b0;
        w_arb_pri = '0;
        w_arb_d   = BG_INDEX;
        if (SP_OPQ) begin
            w_arb_hit = 1'b1;
            w_arb_pri = SP_PRI;
            w_arb_d   = SP_D;
        end else begin
            w_arb_hit = 1'b0;
        end
        if (L0_OPQ && (!w_arb_hit || (L0_PRI > w_arb_pri))) begin
            w_arb_hit = 1'b1;
            w_arb_pri = L0_PRI;
            w_arb_d   = L0_D;
        end else begin
            w_arb_hit = w_arb_hit;
        end
        if (L1_OPQ && (!w_arb_hit || (L1_PRI > w_arb_pri))) begin
            w_arb_hit = 1'b1;
            w_arb_pri = L1_PRI;
            w_arb_d   = L1_D;
        end else begin
            w_arb_hit = w_arb_hit;
        end
    end

    // Sweep FSM next state plus next values for the pixel output stage
    always_comb begin
        w_state_nxt      = r_state;
        w_sweep_cnt_nxt  = r_sweep_cnt;
        w_clut_d_nxt     = r_clut_d;
        w_blank_nxt      = r_blank;
        w_sweep_busy_nxt = r_sweep_busy;
        case (r_state)
            ST_NORMAL: begin
                if (PIX_EN) begin
                    w_clut_d_nxt = w_arb_d;
                    w_blank_nxt  = HBLANK | VBLANK;
                end else begin
                    w_clut_d_nxt = r_clut_d;
                end
                // Start is honoured on any clock, not only on pixel strobes
                if (SWEEP_START) begin
                    w_state_nxt      = ST_SWEEP;
                    w_sweep_cnt_nxt  = 8'h00;
                    w_sweep_busy_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_NORMAL;
                end
            end
            ST_SWEEP: begin
                if (PIX_EN) begin
                    w_clut_d_nxt    = r_sweep_cnt;
                    w_blank_nxt     = 1'b0;
                    w_sweep_cnt_nxt = r_sweep_cnt + 8'd1;
                    if (r_sweep_cnt == 8'hFF) begin
                        w_state_nxt      = ST_NORMAL;
                        w_sweep_busy_nxt = 1'b0;
                    end else begin
                        w_state_nxt = ST_SWEEP;
                    end
                end else begin
                    w_state_nxt = ST_SWEEP;
                end
            end
            default: begin
                w_state_nxt      = ST_NORMAL;
                w_sweep_cnt_nxt  = 8'h00;
                w_sweep_busy_nxt = 1'b0;
            end
        endcase
    end

    // State register and registered pixel outputs
    always_ff @(posedge CLK_6M or negedge CLR) begin
        if (!CLR) begin
            r_state      <= ST_NORMAL;
            r_sweep_cnt  <= 8'h00;
            r_clut_d     <= BG_INDEX;
            r_blank      <= 1'b1;
            r_sweep_busy <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sweep_cnt  <= w_sweep_cnt_nxt;
            r_clut_d     <= w_clut_d_nxt;
            r_blank      <= w_blank_nxt;
            r_sweep_busy <= w_sweep_busy_nxt;
        end
    end

    // Bank deferral: runs every clock independent of PIX_EN and sweep; a
    // request landing on the vblank edge bypasses the pending slot.
    always_ff @(posedge CLK_6M or negedge CLR) begin
        if (!CLR) begin
            r_vblank_prev <= 1'b1;
            r_bank        <= 1'b0;
            r_bank_pend   <= 1'b0;
            r_pend_val    <= 1'b0;
        end else begin
            r_vblank_prev <= VBLANK;
            if (w_vb_rise) begin
                if (BANK_REQ) begin
                    r_bank <= BANK_SEL;
                end else if (r_bank_pend) begin
                    r_bank <= r_pend_val;
                end else begin
                    r_bank <= r_bank;
                end
                r_bank_pend <= 1'b0;
            end else if (BANK_REQ) begin
                r_pend_val  <= BANK_SEL;
                r_bank_pend <= 1'b1;
            end else begin
                r_bank_pend <= r_bank_pend;
            end
        end
    end

    assign CLUT_D     = r_clut_d;
    assign BLANK_OUT  = r_blank;
    assign SWEEP_BUSY = r_sweep_busy;
    assign CLUT_BANK  = r_bank;
    assign BANK_PEND  = r_bank_pend;

endmodule

// File: doc/clut_pixel_arbiter.md
# clut_pixel_arbiter

Per-pixel front end for the CLUT subsystem in the video output path. Each pixel it selects one colour index from two tile layers and the sprite layer using priority and opacity, then drives the CLUT index and bank inputs through a registered output stage. It also handles two side jobs. CPU palette-bank changes are deferred to the next vertical-blank start, so a bank never switches mid-frame. A self-test sweep mode steps all 256 indices through the CLUT.

## Interface
Parameters:
- BG_INDEX, 8'h00: backdrop colour index, used when no layer is opaque.
- PRI_W, 3: priority field width.

Ports:
- CLK_6M in 1: pixel-domain clock, rising-edge.
- CLR in 1: reset, asynchronous, active-low (0 = reset).
- PIX_EN in 1: pixel strobe. Registers advance only when it is 1; tie high for one pixel per clock.
- HBLANK in 1, VBLANK in 1: raster blanking, active-high.
- L0_D in 8, L0_PRI in PRI_W, L0_OPQ in 1: tile layer 0 index, priority, opaque flag.
- L1_D in 8, L1_PRI in PRI_W, L1_OPQ in 1: tile layer 1, same fields.
- SP_D in 8, SP_PRI in PRI_W, SP_OPQ in 1: sprite layer, same fields.
- BANK_REQ in 1: one-cycle CPU request to change palette bank.
- BANK_SEL in 1: requested bank value, sampled with BANK_REQ.
- BANK_PEND out 1: a bank change is waiting for vblank.
- SWEEP_START in 1: one-cycle self-test start pulse.
- SWEEP_BUSY out 1: sweep in progress.
- CLUT_D out 8: CLUT colour index.
- CLUT_BANK out 1: CLUT bank select.
- BLANK_OUT out 1: force-black flag, aligned with CLUT_D.

## Operation
- Reset values:
  - CLUT_D = BG_INDEX, CLUT_BANK = 0, BANK_PEND = 0, BLANK_OUT = 1, SWEEP_BUSY = 0.
  - state = NORMAL, sweep counter = 0.
  - vblank_prev = 1, so VBLANK already high at reset release does not count as an edge.
- Arbitration (NORMAL):
  - Candidates are the layers whose OPQ = 1. The highest PRI (unsigned) wins.
  - Ties go to SP first, then L0, then L1.
  - If no layer is opaque, CLUT_D receives BG_INDEX.
- BLANK_OUT receives HBLANK | VBLANK, in NORMAL only.
- Bank deferral:
  - BANK_REQ = 1 stores BANK_SEL in pend_val and sets BANK_PEND.
  - A later request before application overwrites pend_val; the last request wins.
  - A VBLANK rising edge (VBLANK = 1 and vblank_prev = 0, evaluated every clock regardless of PIX_EN) copies pend_val to CLUT_BANK and clears BANK_PEND.
  - If BANK_REQ coincides with that edge, BANK_SEL goes directly to CLUT_BANK and BANK_PEND stays 0.
  - A request made while VBLANK is already high waits for the next rising edge.
- Sweep FSM, states NORMAL and SWEEP:
  - NORMAL → SWEEP when SWEEP_START = 1: counter = 0, SWEEP_BUSY = 1.
  - In SWEEP, each PIX_EN loads CLUT_D = counter, then increments the counter. BLANK_OUT = 0 and arbitration inputs are ignored.
  - The PIX_EN that loads 8'hFF also returns the FSM to NORMAL and clears SWEEP_BUSY.
  - SWEEP_START while in SWEEP is ignored.
  - Bank deferral keeps running during SWEEP.
- CLR asserted mid-sweep or with a pending bank change: immediate return to reset values, and the pending bank request is discarded.

## Timing
- Arbitration latency: one clock. Inputs sampled at edge n (PIX_EN = 1) appear on CLUT_D and BLANK_OUT after edge n.
- When PIX_EN = 0, CLUT_D and BLANK_OUT hold their values.
- CLUT_BANK changes on the same edge where VBLANK is first sampled high.
- BANK_PEND rises the edge after BANK_REQ.
- SWEEP_START sampled at edge k:
  - SWEEP_BUSY = 1 after edge k.
  - Index 0 is output after the first PIX_EN edge after k.
  - Exactly 256 PIX_EN edges output 00..FF.
  - After the FF edge, CLUT_D = FF and SWEEP_BUSY = 0. Normal arbitration resumes on the next PIX_EN.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- Reset: hold CLR = 0 with random inputs → CLUT_D = 00, CLUT_BANK = 0, BLANK_OUT = 1, BANK_PEND = 0, SWEEP_BUSY = 0.
- Priority: L0 = (12, pri 3, opq), L1 = (34, pri 5, opq), SP = (56, pri 5, opq) → CLUT_D = 56 one clock later. Clear SP_OPQ → 34. Clear all OPQ → BG_INDEX.
- Blanking/hold: HBLANK = 1 → BLANK_OUT = 1 next clock. With PIX_EN = 0 for 3 clocks while inputs change → CLUT_D unchanged.
- Bank deferral:
  - BANK_REQ with BANK_SEL = 1 mid-frame → BANK_PEND = 1, CLUT_BANK = 0 until the VBLANK rise, then CLUT_BANK = 1 and BANK_PEND = 0.
  - Requests 1 then 0 before vblank → CLUT_BANK stays 0.
  - Request on the same edge as the VBLANK rise → applied immediately.
- Sweep: SWEEP_START with PIX_EN = 1 → CLUT_D = 00..FF on consecutive clocks with BLANK_OUT = 0. SWEEP_BUSY falls on the FF edge. A second SWEEP_START mid-sweep does not restart the count.
- Reset mid-operation: assert CLR at sweep index 80 with BANK_PEND = 1 → all outputs at reset values. After release, a VBLANK rise leaves CLUT_BANK = 0.
